ones_counter_63: RTL and testbench
==================================

Name: ones_counter_63

Overview:
- Registered population counter: counts the 1 bits in a 63-bit input word and returns the count as a 6-bit unsigned value.
- Used wherever a one-hot/thermometer or sparse flag vector must be reduced to a count.
- Arithmetic core is a tree of full adders (carry-save reduction followed by a final ripple adder), wrapped by input and output registers on a single clock.

Parameters:
- None. Width fixed at 63 input bits / 6 output bits (max count 63 = 6'b111111 fits exactly).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- A  input  63  data word whose 1 bits are counted; bit 0 is LSB.
- W  output  6  unsigned count of 1 bits in A; registered.

Behaviour:
- Reset: while rst=1, the input register and W are forced to 0 immediately, with no clock needed. On rst deassertion, operation resumes at the next rising clk edge.
- Pipeline: two register stages.
  - Stage 1: A captured into an internal 63-bit register on the rising clk edge.
  - Stage 2: popcount of the stage-1 register captured into W on the next rising edge.
  - Latency is exactly 2 clk cycles from A sampling to W update.
  - Throughput is one new word per cycle.
- Output: W = sum over i=0..62 of A[i], as an exact unsigned 6-bit result. No overflow is possible. Output range is 0..63.
- Arithmetic structure:
  - Reduce the 63 bits with 1-bit full adders grouped into 3:2 compressors.
  - Suggested decomposition: nine 7-bit counters (each built from 4 full adders, producing a 3-bit count), then an adder tree summing the nine 3-bit partial counts to 6 bits.
  - Equivalent correct reductions are acceptable.
  - Behavioural "+" over all 63 bits in a loop is not acceptable: the block must be an explicit adder tree so its timing is predictable.
- Combinational path: the adder tree lies entirely between stage 1 and stage 2, with no other logic in that path.
- Boundary conditions:
  - A = all zeros gives W = 0.
  - A = all ones gives W = 63.
  - A single bit set at either end (bit 0 or bit 62) gives W = 1.
  - A changing every cycle: each word produces its own count 2 cycles later, with no merging or skipping.
- Reset mid-operation:
  - In-flight words are discarded.
  - W reads 0 until two clk edges after rst deasserts.
  - After that, W reflects A as sampled from the first post-reset edge onward.
- No handshake or valid signal. Consumers align to the fixed 2-cycle latency.
- No X propagation from reset state: all registers have defined reset values.

Test Plan:
- Reset: hold rst=1 with A = all ones, then release. W reads 0 during reset and for the first cycle after release. W = 63 on the second rising edge after release.
- Pattern: A has bits [15:2] and [41:30] set, all others 0 (26 ones). W = 26 two cycles after A is applied. Then clear A[5]: W = 25. Then set A[62]: W = 26. Then toggle A[60] to 1: W = 27. Then toggle A[60] back to 0: W = 26. Each update appears exactly 2 cycles after the change.
- Extremes: A = 0 gives W = 0. A = all ones gives W = 63. A = 63'h1 gives W = 1. A = (1<<62) gives W = 1. A = 63'h5555_5555_5555_5555 (bits 0,2,..,62) gives W = 32.
- Back-to-back: apply a different word every cycle for 16 cycles (walking-ones counts 1..16 built cumulatively from bit 0 up). W sequence is 1,2,...,16, each lagging its input by 2 cycles.
- Async reset mid-stream: assert rst between clock edges while counts are flowing. W goes to 0 immediately, without waiting for clk. After release, the stream resumes with correct counts after 2 cycles.
- Random: 1000 random 63-bit words compared against a reference popcount delayed by 2 cycles. No mismatches allowed.

Source files
------------

// File: rtl/ones_counter_63.sv
// ones_counter_63
// Registered population counter for a 63-bit word.
//
// The word is captured in an input register. A full-adder tree between the
// input register and the output register reduces it to a 6-bit count.
// The count is visible on W two rising edges after A is sampled, and a new
// word can be accepted on every cycle.
//
// Reduction structure:
//   level 0 : nine 7:3 counters, each built from four full adders
//   level 1 : three groups of three 3-bit counts, each group reduced by a
//             carry-save row of full adders and then a ripple-carry adder
//   level 2 : the three level-1 sums reduced the same way to the final count
// The carry-save rows and the ripple adders are written as fixed-bound loops
// over a single full-adder function. After elaboration the loops become a
// fixed netlist of full adders, so the depth of the tree does not depend on
// the data.

module ones_counter_63 (
    input  logic        clk,
    input  logic        rst,
    input  logic [62:0] A,
    output logic [5:0]  W
);

    localparam int GROUP_BITS = 7;
    localparam int NUM_GROUPS = 9;
    localparam int NUM_MIDS   = 3;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // One-bit full adder. Returns {carry, sum}.
    function automatic logic [1:0] full_add(
        input logic a,
        input logic b,
        input logic c
    );
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        return {co, s};
    endfunction

    // 7:3 counter built from four full adders.
    // The first two adders compress bits 0..5.
    // The third adder folds in bit 6 at weight 1.
    // The fourth adder combines the three weight-2 carries.
    function automatic logic [2:0] count7(
        input logic [6:0] x
    );
        logic [1:0] fa_lo;
        logic [1:0] fa_hi;
        logic [1:0] fa_w1;
        logic [1:0] fa_w2;
        fa_lo = full_add(x[0], x[1], x[2]);
        fa_hi = full_add(x[3], x[4], x[5]);
        fa_w1 = full_add(fa_lo[0], fa_hi[0], x[6]);
        fa_w2 = full_add(fa_lo[1], fa_hi[1], fa_w1[1]);
        return {fa_w2[1], fa_w2[0], fa_w1[0]};
    endfunction

    // 6-bit ripple-carry adder made of full adders.
    // Carry out of bit 5 is dropped; no operand pair in this tree can
    // produce one, because the total never exceeds 63.
    function automatic logic [5:0] ripple6(
        input logic [5:0] a,
        input logic [5:0] b
    );
        logic [5:0] s;
        logic [1:0] fa;
        logic       c;
        s = 6'd0;
        c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fa   = full_add(a[i], b[i], c);
            s[i] = fa[0];
            c    = fa[1];
        end
        return s;
    endfunction

    // Three-operand adder.
    // A 3:2 carry-save row of full adders produces a sum vector and a carry
    // vector, and ripple6 resolves them.
    // The carry from the top column is dropped for the same range reason as
    // in ripple6.
    function automatic logic [5:0] add3_csa(
        input logic [5:0] a,
        input logic [5:0] b,
        input logic [5:0] c
    );
        logic [5:0] sum_v;
        logic [5:0] car_v;
        logic [1:0] fa;
        sum_v = 6'd0;
        car_v = 6'd0;
        for (int i = 0; i < 6; i++) begin
            fa       = full_add(a[i], b[i], c[i]);
            sum_v[i] = fa[0];
            if (i < 5) begin
                car_v[i + 1] = fa[1];
            end else begin
                car_v[0] = 1'b0;
            end
        end
        return ripple6(sum_v, car_v);
    endfunction

    // ------------------------------------------------------------------
    // Registers and tree signals
    // ------------------------------------------------------------------
    logic [62:0] a_d;
    logic [62:0] a_q;
    logic [5:0]  w_d;
    logic [5:0]  w_q;

    logic [2:0]  grp_cnt_s [NUM_GROUPS];
    logic [5:0]  mid_sum_s [NUM_MIDS];

    // Input stage: the next value of the input register is the raw input word.
    always_comb begin
        a_d = A;
    end

    // Level 0: each 7-bit slice of the registered word goes through a 7:3 counter.
    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_cnt_s[g] = count7(a_q[g * GROUP_BITS +: GROUP_BITS]);
        end
    end

    // Level 1: sum each run of three slice counts. The result is 0..21.
    always_comb begin
        for (int m = 0; m < NUM_MIDS; m++) begin
            mid_sum_s[m] = add3_csa({3'd0, grp_cnt_s[3 * m]},
                                    {3'd0, grp_cnt_s[3 * m + 1]},
                                    {3'd0, grp_cnt_s[3 * m + 2]});
        end
    end

    // Level 2: sum the three level-1 results to form the count. The result is 0..63.
    always_comb begin
        w_d = add3_csa(mid_sum_s[0], mid_sum_s[1], mid_sum_s[2]);
    end

    // Two pipeline stages, both cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= 63'd0;
            w_q <= 6'd0;
        end else begin
            a_q <= a_d;
            w_q <= w_d;
        end
    end

    assign W = w_q;

endmodule

// File: tb/tb_ones_counter_63.sv
// Testbench for ones_counter_63.
// Stimulus pushes the expected count for every word it drives into a
// scoreboard queue. A negedge monitor pops each entry two cycles after it
// was pushed and compares the entry with W.
module tb_ones_counter_63;

    logic        clk;
    logic        rst;
    logic [62:0] A;
    logic [5:0]  W;

    int checks;
    int errors;
    int cycle_cnt;

    typedef struct {
        int         cyc;
        logic [5:0] exp;
        int         tag;
    } sb_item_t;

    sb_item_t sb_q[$];

    localparam logic [62:0] ONES = {63{1'b1}};

    ones_counter_63 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .W   (W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, updated at each rising edge.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference population count, used for the random words.
    function automatic logic [5:0] ref_pop(input logic [62:0] x);
        int n;
        n = 0;
        for (int i = 0; i < 63; i++) n += int'(x[i]);
        return 6'(n);
    endfunction

    // Drive one word just after a rising edge and queue its expected count.
    task automatic drive(input logic [62:0] word, input logic [5:0] exp_v,
                         input logic rst_v, input int tag);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst = rst_v;
        A   = word;
        it.cyc = cycle_cnt;
        it.exp = exp_v;
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    // Monitor: compare each queued expectation two cycles after it was issued.
    always @(negedge clk) begin
        sb_item_t it;
        if (sb_q.size() > 0) begin
            if (sb_q[0].cyc + 2 == cycle_cnt) begin
                it = sb_q.pop_front();
                checks++;
                if (W !== it.exp) begin
                    errors++;
                    $display("FAIL count tag=%0d cycle=%0d: W=%0d expected %0d",
                             it.tag, cycle_cnt, W, it.exp);
                end
            end else if (sb_q[0].cyc + 2 < cycle_cnt) begin
                it = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed tag=%0d issued=%0d now=%0d", it.tag, it.cyc, cycle_cnt);
            end
        end
    end

    initial begin
        logic [63:0] r;
        logic [62:0] w;
        checks    = 0;
        errors    = 0;
        cycle_cnt = 0;
        A   = ONES;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset: W stays 0 while rst is high and for the first cycle after release.
        repeat (3) drive(ONES, 6'd0, 1'b1, 0);
        drive(ONES, 6'd63, 1'b0, 0);
        drive(ONES, 6'd63, 1'b0, 0);

        // Pattern: bits [15:2] and [41:30], then single-bit edits.
        repeat (3) drive(63'h0000_03FF_C000_FFFC, 6'd26, 1'b0, 1);
        repeat (3) drive(63'h0000_03FF_C000_FFDC, 6'd25, 1'b0, 1);
        repeat (3) drive(63'h4000_03FF_C000_FFDC, 6'd26, 1'b0, 1);
        repeat (3) drive(63'h5000_03FF_C000_FFDC, 6'd27, 1'b0, 1);
        repeat (3) drive(63'h4000_03FF_C000_FFDC, 6'd26, 1'b0, 1);

        // Extremes.
        repeat (2) drive(63'd0, 6'd0, 1'b0, 2);
        repeat (2) drive(ONES, 6'd63, 1'b0, 2);
        repeat (2) drive(63'h1, 6'd1, 1'b0, 2);
        repeat (2) drive(63'h4000_0000_0000_0000, 6'd1, 1'b0, 2);
        repeat (2) drive(63'h5555_5555_5555_5555, 6'd32, 1'b0, 2);

        // Back-to-back cumulative walking ones: counts 1..16.
        for (int k = 1; k <= 16; k++)
            drive((63'd1 << k) - 63'd1, 6'(k), 1'b0, 3);

        // Asynchronous reset while counts are flowing.
        for (int k = 1; k <= 6; k++)
            drive((63'd1 << (k + 20)) - 63'd1, 6'(k + 20), 1'b0, 4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (W !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: W=%0d expected 0", W);
        end
        for (int i = 0; i < sb_q.size(); i++) sb_q[i].exp = 6'd0;
        drive(ONES, 6'd0, 1'b1, 4);
        drive(ONES, 6'd0, 1'b1, 4);
        drive(63'h0000_0000_0000_00FF, 6'd8, 1'b0, 4);
        drive(63'h7000_0000_0000_0001, 6'd4, 1'b0, 4);
        drive(ONES, 6'd63, 1'b0, 4);

        // Random words checked against the reference count.
        for (int n = 0; n < 1000; n++) begin
            r = {$urandom(), $urandom()};
            if (n % 3 == 1) r = r & {$urandom(), $urandom()};
            if (n % 3 == 2) r = r | {$urandom(), $urandom()};
            w = r[62:0];
            drive(w, ref_pop(w), 1'b0, 5);
        end

        // Drain the scoreboard within a bounded number of cycles.
        repeat (10) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
